load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; address and data widths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  execute stage presents a load/store request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse; there is no backpressure.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-013 resp_misaligned  output  1  request faulted; valid only with resp_valid.
REQ-014 mem_addr  output  32  word address to data memory, bits [1:0] = 00.
REQ-015 mem_we  output  1  data memory write enable.
REQ-016 mem_w_data  output  32  data memory write word.
REQ-017 mem_r_data  input  32  data memory read word for mem_addr.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPT, WRITE and RESP; req_ready SHALL be 1 only in IDLE while rst=0.
REQ-019 Acceptance in cycle T (IDLE with req_valid=1) SHALL register the size, addr, wdata, we and unsigned fields.
REQ-020 Fault conditions: size=11, or half with addr[0]=1, or word with addr[1:0]!=00.
REQ-021 On a fault: IDLE->RESP, no memory access, resp_valid=1 at T+1 with resp_misaligned=1 and resp_rdata=0.
REQ-022 Load sequence: IDLE->READ(T+1)->CAPT(T+2)->RESP(T+3), with resp_valid=1 at T+3.
REQ-023 Word store sequence: IDLE->WRITE(T+1)->RESP(T+2), with mem_w_data=wdata.
REQ-024 Sub-word store sequence: IDLE->READ->CAPT->WRITE->RESP, with resp_valid=1 at T+4.
REQ-025 mem_addr SHALL equal {addr[31:2],2'b00} and stay stable from READ through WRITE.
REQ-026 Lane mapping SHALL be little-endian: byte n occupies bits [8n+7:8n], where n = addr[1:0].
REQ-027 In CAPT, loads SHALL extract the addressed lane(s) and sign- or zero-extend them into a result register.
REQ-028 In CAPT, sub-word stores SHALL register the read word with only the target lane(s) replaced by wdata[7:0] or wdata[15:0].
REQ-029 mem_we SHALL be 1 only in WRITE, for exactly one cycle per store, gated combinationally with !rst.
REQ-030 resp_rdata SHALL hold its last value until the next resp_valid.
REQ-031 resp_misaligned SHALL hold its last value until the next resp_valid.
REQ-032 RESP SHALL always return to IDLE, so back-to-back requests are spaced with req_ready=0 throughout the busy cycles.
REQ-033 Inputs changing while busy SHALL have no effect.

Reset
REQ-034 While rst is sampled high: state=IDLE, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_addr=0, mem_w_data=0 and mem_we=0.
REQ-035 Reset mid-operation SHALL abort the request with no response and no memory write in the reset cycle.
REQ-036 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-037 Word store of 0x00054321 to 0x00012344, then a word load from the same address -> mem_we=1 for one cycle at T+1 with mem_addr=0x00012344, and the load returns resp_rdata=0x00054321 at T+3.
REQ-038 Word 0x100 preloaded with 0x11223344; byte store 0xAB to 0x101 -> word becomes 0x1122AB44; a signed byte load from 0x101 -> 0xFFFFFFAB; an unsigned byte load -> 0x000000AB.
REQ-039 Half store 0x8001 to 0x102 over 0x1122AB44 -> word becomes 0x8001AB44; a signed half load from 0x102 -> 0xFFFF8001; an unsigned half load -> 0x00008001.
REQ-040 Word load from 0x101, half store to 0x103, and size=11 -> each gives resp_valid at T+1 with resp_misaligned=1 and resp_rdata=0, and mem_we stays 0.
REQ-041 req_valid held high for two loads -> req_ready=0 in T+1..T+3, and the second request is accepted at T+4.
REQ-042 rst pulsed in the WRITE cycle of a byte store -> mem_we=0, the memory word is unchanged, no resp_valid occurs, and req_ready=1 on the first cycle after reset.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle between the execute stage, the load/store unit and the data memory.
// The slave modport is the load/store unit's view; master is the surrounding system.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_r_data,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_we, mem_w_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_r_data,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_we, mem_w_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word accesses to a word-wide memory,
// with read-modify-write for sub-word stores and alignment fault detection.
module load_store_unit (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e      state_q;
    logic        we_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;
    logic        resp_valid_q;
    logic        resp_misaligned_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_w_data_q;
    logic        mem_we_q;

    logic        fault_d;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;

    always_comb begin
        // NOTE: default first, so no branch of the case can leave fault_d unassigned (latch).
        fault_d = 1'b0;
        case (bus.req_size)
            SZ_BYTE: fault_d = 1'b0;
            SZ_HALF: fault_d = bus.req_addr[0];
            SZ_WORD: fault_d = |bus.req_addr[1:0];
            default: fault_d = 1'b1;
        endcase
    end

    // Little-endian lane select on the captured read word, plus the merged store word.
    always_comb begin
        lane_b       = bus.mem_r_data[{offset_q, 3'b000} +: 8];
        lane_h       = bus.mem_r_data[{offset_q[1], 4'b0000} +: 16];
        load_data_d  = bus.mem_r_data;
        merge_data_d = bus.mem_r_data;
        case (size_q)
            SZ_BYTE: begin
                load_data_d = unsigned_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merge_data_d[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_data_d = unsigned_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
                merge_data_d[{offset_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            we_q              <= 1'b0;
            unsigned_q        <= 1'b0;
            size_q            <= 2'b00;
            offset_q          <= 2'b00;
            wdata_q           <= 16'h0;
            resp_valid_q      <= 1'b0;
            resp_misaligned_q <= 1'b0;
            resp_rdata_q      <= 32'h0;
            mem_addr_q        <= 32'h0;
            mem_w_data_q      <= 32'h0;
            mem_we_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision here sees pre-edge values.
            resp_valid_q <= 1'b0;
            mem_we_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q       <= bus.req_we;
                        unsigned_q <= bus.req_unsigned;
                        size_q     <= bus.req_size;
                        offset_q   <= bus.req_addr[1:0];
                        wdata_q    <= bus.req_wdata[15:0];
                        if (fault_d) begin
                            resp_valid_q      <= 1'b1;
                            resp_rdata_q      <= 32'h0;
                            resp_misaligned_q <= 1'b1;
                            state_q           <= RESP;
                        end else begin
                            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                            if (bus.req_we && bus.req_size == SZ_WORD) begin
                                mem_w_data_q <= bus.req_wdata;
                                mem_we_q     <= 1'b1;
                                state_q      <= WRITE;
                            end else begin
                                state_q <= READ;
                            end
                        end
                    end
                end
                READ: state_q <= CAPT;
                CAPT: begin
                    if (we_q) begin
                        mem_w_data_q <= merge_data_d;
                        mem_we_q     <= 1'b1;
                        state_q      <= WRITE;
                    end else begin
                        resp_valid_q      <= 1'b1;
                        resp_rdata_q      <= load_data_d;
                        resp_misaligned_q <= 1'b0;
                        state_q           <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid_q      <= 1'b1;
                    resp_rdata_q      <= 32'h0;
                    resp_misaligned_q <= 1'b0;
                    state_q           <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A reset landing in WRITE must suppress the memory write in that same cycle.
    assign bus.req_ready       = (state_q == IDLE) && !rst;
    assign bus.mem_we          = mem_we_q && !rst;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_misaligned = resp_misaligned_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_w_data      = mem_w_data_q;
endmodule
